reg_dump_scanner: RTL and testbench

//  Reader for the CPU debug register port (reg_sel -> reg_data) of the pipeline core.
//  On a start pulse it walks reg_sel through x0..x(NUM_REGS-1) and samples reg_data after a settle delay.

---
 rtl/reg_dump_pkg.sv | 16 +
 rtl/reg_dump_csum_acc.sv | 25 ++
 rtl/reg_dump_scanner.sv | 170 +++++++++++++++++
 tb/tb_reg_dump_scanner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared state encoding and default sizes for the register dump scanner
package reg_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SEND,
    ST_CSUM,
    ST_DONE
  } state_t;

  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_DATA_W   = 32;
  localparam int CSUM_IDX         = DEFAULT_NUM_REGS;

endpackage

// File: rtl/reg_dump_csum_acc.sv
// rtl/reg_dump_csum_acc.sv - running XOR accumulator with clear and enable
module reg_dump_csum_acc #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_acc
);

  logic [DATA_W-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/reg_dump_scanner.sv
// rtl/reg_dump_scanner.sv - walks the core debug register port and streams each register as one beat
// Optional REG_DUMP_CHECKSUM_EN appends an XOR checksum beat at index NUM_REGS.
module reg_dump_scanner
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS      = DEFAULT_NUM_REGS,
  parameter int SEL_W         = $clog2(NUM_REGS),
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W:0]    out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [SEL_W-1:0]  r_reg_sel;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W:0]    r_out_idx;
  logic              r_out_last;
  logic              r_busy;
  logic              r_done;

  logic w_hs;
  logic w_last_reg;
  logic w_start_ok;

  assign w_hs       = r_out_valid & out_ready;
  assign w_last_reg = (r_reg_sel == LAST_SEL);
  assign w_start_ok = (r_state == ST_IDLE) & start & ~abort;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [SEL_W:0] CSUM_OUT_IDX = (SEL_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] w_csum;
  logic              w_csum_en;

  assign w_csum_en = (r_state == ST_SEND) & w_hs & ~abort;

  reg_dump_csum_acc #(
    .DATA_W (DATA_W)
  ) u_csum_acc (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start_ok),
    .i_en   (w_csum_en),
    .i_data (r_out_data),
    .o_acc  (w_csum)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_reg_sel   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort && (r_state != ST_IDLE)) begin
      // abort outranks any handshake landing on the same edge
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_reg_sel   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state   <= ST_SELECT;
            r_reg_sel <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
          end
        end
        ST_SELECT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == SETTLE_LAST) begin
            r_out_data  <= reg_data;
            r_out_idx   <= {1'b0, r_reg_sel};
`ifdef REG_DUMP_CHECKSUM_EN
            r_out_last  <= 1'b0;
`else
            r_out_last  <= w_last_reg;
`endif
            r_out_valid <= 1'b1;
            r_state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            if (w_last_reg) begin
`ifdef REG_DUMP_CHECKSUM_EN
              // accumulator has not absorbed this beat yet, so fold it in here
              r_out_data <= w_csum ^ r_out_data;
              r_out_idx  <= CSUM_OUT_IDX;
              r_out_last <= 1'b1;
              r_state    <= ST_CSUM;
`else
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_reg_sel   <= '0;
              r_done      <= 1'b1;
              r_state     <= ST_DONE;
`endif
            end else begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_reg_sel   <= r_reg_sel + SEL_W'(1);
              r_cnt       <= '0;
              r_state     <= ST_SELECT;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_reg_sel   <= '0;
            r_done      <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign reg_sel   = r_reg_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_reg_dump_scanner.sv
// tb/tb_reg_dump_scanner.sv - directed self-checking bench for reg_dump_scanner
// Checksum expectations apply when REG_DUMP_CHECKSUM_EN is defined.
module tb_reg_dump_scanner;

  localparam int NREG = 32;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int N_BEATS = NREG + 1;
  localparam int DONE_K  = 65;
`else
  localparam int N_BEATS = NREG;
  localparam int DONE_K  = 64;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;

  reg_dump_scanner dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .reg_sel   (reg_sel),
    .reg_data  (reg_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input int i);
    if (i == 0) return 32'h0;
    if (i == NREG) return 32'h1000_0000;
    return 32'(32'h1000_0000 + i);
  endfunction

  always_comb reg_data = model(int'(reg_sel));

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({reg_sel, out_idx} !== 11'h0) $display("FAIL reset_sel_idx: got %h expected 0", {reg_sel, out_idx}); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL reset_data: got %h expected 0", out_data); else passed++;
    total++; if ({out_valid, out_last, busy, done} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {out_valid, out_last, busy, done}); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // start is sampled at E0; restart_edge re-pulses start at that edge (0 = never)
  task automatic run_scan(input int restart_edge, input string tag);
    int beat = 0;
    int n_done = 0;
    int done_k = -1;
    int bad = 0;
    int exp_hs;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 72; k++) begin
      if (out_valid === 1'b1) begin
        exp_hs = (beat < NREG) ? 2 + 2 * beat : 65;
        if (out_idx !== 6'(beat) || out_data !== model(beat) || (k + 1) != exp_hs ||
            out_last !== (beat == N_BEATS - 1) || (beat < NREG && reg_sel !== 5'(beat))) begin
          if (bad < 4)
            $display("FAIL %s_beat%0d: got idx=%0d data=%h last=%b sel=%0d edge=%0d expected idx=%0d data=%h last=%b edge=%0d",
                     tag, beat, out_idx, out_data, out_last, reg_sel, k + 1, beat, model(beat), beat == N_BEATS - 1, exp_hs);
          bad++;
        end
        beat++;
      end
      if (done === 1'b1) begin
        n_done++;
        done_k = k;
      end
      start = ((k + 1) == restart_edge);
      @(negedge clk);
    end
    total++; if (bad != 0) $display("FAIL %s_beats: got %0d bad beats expected 0", tag, bad); else passed++;
    total++; if (beat != N_BEATS) $display("FAIL %s_count: got %0d expected %0d", tag, beat, N_BEATS); else passed++;
    total++; if (n_done != 1 || done_k != DONE_K) $display("FAIL %s_done: got %0d pulses at %0d expected 1 at %0d", tag, n_done, done_k, DONE_K); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL %s_busy_after: got %b expected 0", tag, busy); else passed++;
  endtask

  task automatic wait_idx(input int idx, input string tag);
    int w = 0;
    while (!(out_valid === 1'b1 && out_idx == 6'(idx)) && w < 60) begin
      @(negedge clk);
      w++;
    end
    total++; if (w >= 60) $display("FAIL %s_wait: got timeout expected idx %0d valid", tag, idx); else passed++;
  endtask

  task automatic test_full_scan();
    run_scan(0, "full");
  endtask

  task automatic test_restart_ignored();
    run_scan(10, "restart");
  endtask

  task automatic test_backpressure();
    int bad = 0;
    int w = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idx(3, "bp");
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 32'h1000_0003 || out_idx !== 6'd3 || reg_sel !== 5'd3) begin
        $display("FAIL bp_hold: got valid=%b data=%h idx=%0d sel=%0d expected 1 10000003 3 3", out_valid, out_data, out_idx, reg_sel);
        bad++;
      end
    end
    total++; if (bad != 0) $display("FAIL bp_hold_total: got %0d bad cycles expected 0", bad); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    while (out_valid !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    total++; if (out_idx !== 6'd4 || out_data !== 32'h1000_0004) $display("FAIL bp_resume: got idx=%0d data=%h expected 4 10000004", out_idx, out_data); else passed++;
    w = 0;
    while (done !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    total++; if (w >= 100) $display("FAIL bp_done: got timeout expected done pulse"); else passed++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int bad = 0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL start_abort_idle: got busy=%b expected 0", busy); else passed++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idx(7, "abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if ({out_valid, busy, out_last, done} !== 4'b0) $display("FAIL abort_flags: got %b expected 0000", {out_valid, busy, out_last, done}); else passed++;
    total++; if (reg_sel !== 5'd0) $display("FAIL abort_sel: got %0d expected 0", reg_sel); else passed++;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); else passed++;
    run_scan(0, "rescan");
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idx(12, "rst");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({reg_sel, out_idx} !== 11'h0 || out_data !== 32'h0) $display("FAIL rst_mid_regs: got sel=%0d idx=%0d data=%h expected 0 0 0", reg_sel, out_idx, out_data); else passed++;
    total++; if ({out_valid, out_last, busy, done} !== 4'b0) $display("FAIL rst_mid_flags: got %b expected 0000", {out_valid, out_last, busy, done}); else passed++;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", bad); else passed++;
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_backpressure();
    test_restart_ignored();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
